// File: rtl/sample_pair_packer.sv
// Packs consecutive decimator samples into 2*SAMPLE_WIDTH words and buffers them in a FWFT FIFO.
// Optional drop counter output ovf_count is enabled by defining SAMPLE_PAIR_PACKER_OVF_CNT_EN.
module sample_pair_packer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [SAMPLE_WIDTH-1:0]       data_in,
  input  logic                          flush,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [2*SAMPLE_WIDTH-1:0]     m_data,
  output logic                          m_partial,
  output logic                          overflow,
`ifdef SAMPLE_PAIR_PACKER_OVF_CNT_EN
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [15:0]                   ovf_count
`else
  output logic [$clog2(FIFO_DEPTH):0]   level
`endif
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {EMPTY, HALF} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   hold_q, hold_d;
  logic            pushReq;
  logic [2*SW-1:0] pushData;
  logic            pushPartial;

  logic [2*SW:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic            fifoEmpty, fifoFull, pop, doPush, drop;
  logic            overflow_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    pushReq     = 1'b0;
    pushData    = '0;
    pushPartial = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (valid_in && flush) begin
          pushReq     = 1'b1;
          pushData    = {{SW{1'b0}}, data_in};
          pushPartial = 1'b1;
        end else if (valid_in) begin
          hold_d  = data_in;
          state_d = HALF;
        end
      end
      HALF: begin
        // A new sample always completes the pair; a concurrent flush has nothing left to pad.
        if (valid_in) begin
          pushReq  = 1'b1;
          pushData = {data_in, hold_q};
          state_d  = EMPTY;
        end else if (flush) begin
          pushReq     = 1'b1;
          pushData    = {{SW{1'b0}}, hold_q};
          pushPartial = 1'b1;
          state_d     = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[PW-1] != rdPtr_q[PW-1]) &&
                     (wrPtr_q[PW-2:0] == rdPtr_q[PW-2:0]);
  assign pop       = !fifoEmpty && m_ready;
  // When full, a same-cycle pop frees the head slot that the write pointer aliases.
  assign doPush    = pushReq && (!fifoFull || pop);
  assign drop      = pushReq && fifoFull && !pop;

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q[PW-2:0]] <= {pushPartial, pushData};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)    rdPtr_q <= rdPtr_q + 1'b1;
      if (drop)   overflow_q <= 1'b1;
    end
  end

  assign m_valid   = !fifoEmpty;
  assign m_data    = fifoEmpty ? '0   : mem[rdPtr_q[PW-2:0]][2*SW-1:0];
  assign m_partial = fifoEmpty ? 1'b0 : mem[rdPtr_q[PW-2:0]][2*SW];
  assign overflow  = overflow_q;
  assign level     = wrPtr_q - rdPtr_q;

`ifdef SAMPLE_PAIR_PACKER_OVF_CNT_EN
  logic [15:0] ovfCount_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              ovfCount_q <= '0;
    else if (drop && ovfCount_q != 16'hFFFF) ovfCount_q <= ovfCount_q + 16'd1;
  end

  assign ovf_count = ovfCount_q;
`endif

endmodule

// File: tb/tb_sample_pair_packer.sv
// Scoreboard bench for sample_pair_packer: directed stimulus queues expected words, a monitor checks pops.
module tb_sample_pair_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] data_in = '0;
  logic        flush = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_partial;
  logic        overflow;
  logic [3:0]  level;
`ifdef SAMPLE_PAIR_PACKER_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [32:0] expQ [$];

  sample_pair_packer #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_partial(m_partial),
    .overflow(overflow),
`ifdef SAMPLE_PAIR_PACKER_OVF_CNT_EN
    .level(level), .ovf_count(ovf_count)
`else
    .level(level)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs and returns just after the edge that consumed them.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic f);
    valid_in = v;
    data_in  = d;
    flush    = f;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic expectWord(input logic p, input logic [31:0] w);
    expQ.push_back({p, w});
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    checkOutput("rst_m_valid", {32'd0, m_valid}, 33'd0);
    checkOutput("rst_m_data", {1'b0, m_data}, 33'd0);
    checkOutput("rst_m_partial", {32'd0, m_partial}, 33'd0);
    checkOutput("rst_overflow", {32'd0, overflow}, 33'd0);
    checkOutput("rst_level", {29'd0, level}, 33'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    expQ.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && expQ.size() != 0; i++) applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("drain_empty", 33'(expQ.size()), 33'd0);
  endtask

  initial begin
    fork
      forever begin
        logic [32:0] exp;
        @(negedge clk);
        if (!reset && m_valid && m_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL word_unexpected got=%h expected=none", {m_partial, m_data});
          end else begin
            exp = expQ.pop_front();
            checkOutput("word", {m_partial, m_data}, exp);
          end
        end
      end
    join_none

    @(posedge clk);
    #1;
    doReset();

    // Basic pack with latency checks
    m_ready = 1'b1;
    expectWord(1'b0, 32'h0002_0001);
    expectWord(1'b0, 32'h0004_0003);
    applyStimulus(1'b1, 16'h0001, 1'b0);
    checkOutput("pack_lat0", {32'd0, m_valid}, 33'd0);
    applyStimulus(1'b1, 16'h0002, 1'b0);
    checkOutput("pack_lat1", {m_partial, m_data}, {1'b0, 32'h0002_0001});
    applyStimulus(1'b1, 16'h0003, 1'b0);
    checkOutput("pack_popped", {32'd0, m_valid}, 33'd0);
    applyStimulus(1'b1, 16'h0004, 1'b0);
    checkOutput("pack_word2", {m_partial, m_data}, {1'b0, 32'h0004_0003});
    drain();

    // Flush of a held half-pair, then normal packing resumes
    expectWord(1'b1, 32'h0000_1234);
    expectWord(1'b0, 32'h0006_0005);
    applyStimulus(1'b1, 16'h1234, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("flush_word", {m_partial, m_data}, {1'b1, 32'h0000_1234});
    applyStimulus(1'b1, 16'h0005, 1'b0);
    applyStimulus(1'b1, 16'h0006, 1'b0);
    drain();

    // Back-pressure: 10 words into an 8-deep FIFO, last two dropped
    doReset();
    m_ready = 1'b0;
    for (int j = 0; j < 8; j++)
      expectWord(1'b0, {16'(16'h0101 + 2*j), 16'(16'h0100 + 2*j)});
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b1, 16'(16'h0100 + n), 1'b0);
      if (n == 15) checkOutput("bp_full_noovf", {29'd0, level, overflow}, {29'd8, 1'b0});
      if (n == 17) checkOutput("bp_first_drop", {32'd0, overflow}, 33'd1);
    end
    checkOutput("bp_level", {29'd0, level}, 33'd8);
    checkOutput("bp_overflow", {32'd0, overflow}, 33'd1);
`ifdef SAMPLE_PAIR_PACKER_OVF_CNT_EN
    checkOutput("bp_ovf_count", {17'd0, ovf_count}, 33'd2);
`endif
    m_ready = 1'b1;
    drain();
    checkOutput("bp_level_after", {29'd0, level}, 33'd0);
    checkOutput("bp_ovf_sticky", {32'd0, overflow}, 33'd1);

    // Push into a full FIFO on the same edge as a pop
    doReset();
    m_ready = 1'b0;
    for (int j = 0; j < 8; j++)
      expectWord(1'b0, {16'(16'h0201 + 2*j), 16'(16'h0200 + 2*j)});
    expectWord(1'b0, 32'h02B0_02A0);
    for (int n = 0; n < 16; n++) applyStimulus(1'b1, 16'(16'h0200 + n), 1'b0);
    applyStimulus(1'b1, 16'h02A0, 1'b0);
    m_ready = 1'b1;
    applyStimulus(1'b1, 16'h02B0, 1'b0);
    checkOutput("fullpop_level", {29'd0, level, overflow}, {29'd8, 1'b0});
    drain();
    checkOutput("fullpop_noovf", {32'd0, overflow}, 33'd0);

    // Flush coinciding with valid_in in each state
    expectWord(1'b0, 32'h5555_AAAA);
    expectWord(1'b1, 32'h0000_7777);
    applyStimulus(1'b1, 16'hAAAA, 1'b0);
    applyStimulus(1'b1, 16'h5555, 1'b1);
    checkOutput("fv_half", {m_partial, m_data}, {1'b0, 32'h5555_AAAA});
    applyStimulus(1'b1, 16'h7777, 1'b1);
    checkOutput("fv_empty", {m_partial, m_data}, {1'b1, 32'h0000_7777});
    drain();

    // Reset mid-stream with queued words and a held sample
    m_ready = 1'b0;
    for (int n = 0; n < 7; n++) applyStimulus(1'b1, 16'(16'h0300 + n), 1'b0);
    checkOutput("mid_level", {29'd0, level}, 33'd3);
    doReset();
    m_ready = 1'b1;
    expectWord(1'b0, 32'hCAFE_BEEF);
    applyStimulus(1'b1, 16'hBEEF, 1'b0);
    checkOutput("post_rst_empty", {32'd0, m_valid}, 33'd0);
    applyStimulus(1'b1, 16'hCAFE, 1'b0);
    checkOutput("post_rst_word", {m_partial, m_data}, {1'b0, 32'hCAFE_BEEF});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
